// File: rtl/kronos_types.sv
// Shared types for the Kronos execute stage.
// The ALU opcode encoding is width-independent.
package kronos_types;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASS2 = 4'd10
  } alu_op_t;

endpackage

// File: rtl/kronos_shift_iter.sv
// Iterative shifter: one bit per cycle, with a working register and a countdown.
//   state   | meaning
//   S_IDLE  | waiting for a shift with non-zero shamt
//   S_SHIFT | shifting one bit per cycle, cnt_q counts the remaining bits
module kronos_shift_iter
  import kronos_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rstz,
  input  logic                    start_i,
  input  alu_op_t                 op_i,
  input  logic [XLEN-1:0]         data_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  output logic                    busy_o,
  output logic                    last_o,
  output logic [XLEN-1:0]         data_o
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          state_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] work_q;
  alu_op_t         op_q;
  logic            busy_q;
  logic [XLEN-1:0] step_d;

  always_comb begin
    case (op_q)
      ALU_SLL: step_d = {work_q[XLEN-2:0], 1'b0};
      ALU_SRA: step_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: step_d = {1'b0, work_q[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      op_q    <= ALU_ADD;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_SHIFT;
            cnt_q   <= shamt_i;
            work_q  <= data_i;
            op_q    <= op_i;
            busy_q  <= 1'b1;
          end
        end
        S_SHIFT: begin
          work_q <= step_d;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The final step is handed out combinationally so the result lands on the cnt=1 edge.
  assign busy_o = busy_q;
  assign last_o = (state_q == S_SHIFT) && (cnt_q == SHW'(1));
  assign data_o = step_d;

endmodule

// File: rtl/kronos_ex_pipe.sv
// Kronos execute stage: forwarding select, ALU, optional iterative shifter,
// and a single output register held until WriteBack accepts it.
module kronos_ex_pipe
  import kronos_types::*;
#(
  parameter int XLEN       = 32,
  parameter int NFWD       = 2,
  parameter int TAGW       = 16,
  parameter int SHIFT_ITER = 0
) (
  input  logic                 clk,
  input  logic                 rstz,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  alu_op_t              in_op,
  input  logic [XLEN-1:0]      in_op1,
  input  logic [XLEN-1:0]      in_op2,
  input  logic [NFWD-1:0]      in_hz1,
  input  logic [NFWD-1:0]      in_hz2,
  input  logic [TAGW-1:0]      in_tag,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_vld,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [XLEN-1:0]      out_result,
  output logic [TAGW-1:0]      out_tag
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] op1_sel, op2_sel, alu_res, shift_res, shift_fin;
  logic [SHW-1:0]  shamt;
  logic            stall, busy, accept, start_iter, shift_last;
  logic            out_vld_q, out_vld_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;

  // Per-operand priority encoder: the lowest flagged index wins.
  for (genvar k = 0; k < 2; k++) begin : g_opsel
    logic [NFWD-1:0] hz;
    logic [XLEN-1:0] raw, sel;
    logic            wait_fwd;
    assign hz  = (k == 0) ? in_hz1 : in_hz2;
    assign raw = (k == 0) ? in_op1 : in_op2;
    always_comb begin
      sel      = raw;
      wait_fwd = 1'b0;
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (hz[i]) begin
          sel      = fwd_data[i*XLEN +: XLEN];
          wait_fwd = ~fwd_vld[i];
        end
      end
    end
  end

  assign op1_sel = g_opsel[0].sel;
  assign op2_sel = g_opsel[1].sel;
  assign stall   = g_opsel[0].wait_fwd | g_opsel[1].wait_fwd;
  assign shamt   = op2_sel[SHW-1:0];

  assign in_rdy  = rstz & (~out_vld_q | out_rdy) & ~busy & ~stall;
  assign accept  = in_vld & in_rdy;

  if (SHIFT_ITER != 0) begin : g_iter
    logic is_shift;
    assign is_shift   = (in_op == ALU_SLL) || (in_op == ALU_SRL) || (in_op == ALU_SRA);
    assign start_iter = accept & is_shift & (shamt != '0);
    // Only shamt=0 shifts take the single-cycle path here.
    assign shift_res  = op1_sel;
    kronos_shift_iter #(.XLEN(XLEN)) u_shift (
      .clk     (clk),
      .rstz    (rstz),
      .start_i (start_iter),
      .op_i    (in_op),
      .data_i  (op1_sel),
      .shamt_i (shamt),
      .busy_o  (busy),
      .last_o  (shift_last),
      .data_o  (shift_fin)
    );
  end else begin : g_barrel
    always_comb begin
      case (in_op)
        ALU_SLL: shift_res = op1_sel << shamt;
        ALU_SRA: shift_res = $unsigned($signed(op1_sel) >>> shamt);
        default: shift_res = op1_sel >> shamt;
      endcase
    end
    assign start_iter = 1'b0;
    assign busy       = 1'b0;
    assign shift_last = 1'b0;
    assign shift_fin  = '0;
  end

  always_comb begin
    case (in_op)
      ALU_ADD:   alu_res = op1_sel + op2_sel;
      ALU_SUB:   alu_res = op1_sel - op2_sel;
      ALU_AND:   alu_res = op1_sel & op2_sel;
      ALU_OR:    alu_res = op1_sel | op2_sel;
      ALU_XOR:   alu_res = op1_sel ^ op2_sel;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_sel) < $signed(op2_sel))};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op1_sel < op2_sel)};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = shift_res;
      ALU_PASS2: alu_res = op2_sel;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    out_vld_d    = out_vld_q & ~out_rdy;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (accept) out_tag_d = in_tag;
    if (accept && !start_iter) begin
      out_vld_d    = 1'b1;
      out_result_d = alu_res;
    end else if (shift_last) begin
      out_vld_d    = 1'b1;
      out_result_d = shift_fin;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      out_vld_q    <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_kronos_ex_pipe.sv
// Scoreboard bench: a 32-bit iterative-shift instance and a 64-bit barrel-shift instance.
module tb_kronos_ex_pipe;
  import kronos_types::*;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // 32-bit, SHIFT_ITER=1
  logic        a_rstz, a_in_vld, a_in_rdy, a_out_vld, a_out_rdy;
  alu_op_t     a_in_op;
  logic [31:0] a_in_op1, a_in_op2, a_out_result;
  logic [1:0]  a_in_hz1, a_in_hz2, a_fwd_vld;
  logic [15:0] a_in_tag, a_out_tag;
  logic [63:0] a_fwd_data;

  // 64-bit, SHIFT_ITER=0
  logic        b_rstz, b_in_vld, b_in_rdy, b_out_vld, b_out_rdy;
  alu_op_t     b_in_op;
  logic [63:0] b_in_op1, b_in_op2, b_out_result;
  logic [1:0]  b_in_hz1, b_in_hz2, b_fwd_vld;
  logic [7:0]  b_in_tag, b_out_tag;
  logic [127:0] b_fwd_data;

  logic [47:0] qa[$];
  logic [71:0] qb[$];

  kronos_ex_pipe #(.XLEN(32), .NFWD(2), .TAGW(16), .SHIFT_ITER(1)) dut_a (
    .clk(clk), .rstz(a_rstz), .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_op(a_in_op),
    .in_op1(a_in_op1), .in_op2(a_in_op2), .in_hz1(a_in_hz1), .in_hz2(a_in_hz2),
    .in_tag(a_in_tag), .fwd_data(a_fwd_data), .fwd_vld(a_fwd_vld), .out_vld(a_out_vld),
    .out_rdy(a_out_rdy), .out_result(a_out_result), .out_tag(a_out_tag)
  );

  kronos_ex_pipe #(.XLEN(64), .NFWD(2), .TAGW(8), .SHIFT_ITER(0)) dut_b (
    .clk(clk), .rstz(b_rstz), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_op(b_in_op),
    .in_op1(b_in_op1), .in_op2(b_in_op2), .in_hz1(b_in_hz1), .in_hz2(b_in_hz2),
    .in_tag(b_in_tag), .fwd_data(b_fwd_data), .fwd_vld(b_fwd_vld), .out_vld(b_out_vld),
    .out_rdy(b_out_rdy), .out_result(b_out_result), .out_tag(b_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic send_a(input alu_op_t op, input logic [31:0] x, input logic [31:0] y,
                        input logic [15:0] tag, input logic [31:0] exp, input bit push);
    int n = 0;
    a_in_op = op; a_in_op1 = x; a_in_op2 = y; a_in_tag = tag; a_in_vld = 1'b1;
    @(negedge clk);
    while (!a_in_rdy && n < 60) begin n++; @(negedge clk); end
    if (!a_in_rdy) begin
      checks++; errors++;
      $display("FAIL a_send_timeout in_rdy=%b exp=1", a_in_rdy);
    end else if (push) qa.push_back({exp, tag});
    @(posedge clk); #1;
    a_in_vld = 1'b0;
  endtask

  task automatic send_b(input alu_op_t op, input logic [63:0] x, input logic [63:0] y,
                        input logic [7:0] tag, input logic [63:0] exp);
    int n = 0;
    b_in_op = op; b_in_op1 = x; b_in_op2 = y; b_in_tag = tag; b_in_vld = 1'b1;
    @(negedge clk);
    while (!b_in_rdy && n < 60) begin n++; @(negedge clk); end
    if (!b_in_rdy) begin
      checks++; errors++;
      $display("FAIL b_send_timeout in_rdy=%b exp=1", b_in_rdy);
    end else qb.push_back({exp, tag});
    @(posedge clk); #1;
    b_in_vld = 1'b0;
  endtask

  // Monitors: pop on each handshake, and verify held outputs while stalled.
  logic        a_hold = 1'b0;
  logic [31:0] a_hold_res;
  logic [15:0] a_hold_tag;
  always @(negedge clk) begin : mon_a
    logic [47:0] e;
    if (a_hold) begin
      chk("a_hold_vld", 64'(a_out_vld), 64'd1);
      chk("a_hold_res", 64'(a_out_result), 64'(a_hold_res));
      chk("a_hold_tag", 64'(a_out_tag), 64'(a_hold_tag));
    end
    a_hold = 1'b0;
    if (a_out_vld) begin
      if (!a_out_rdy) begin
        a_hold = 1'b1; a_hold_res = a_out_result; a_hold_tag = a_out_tag;
      end else if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra_output got=%h exp=none", a_out_result);
      end else begin
        e = qa.pop_front();
        chk("a_result", 64'(a_out_result), 64'(e[47:16]));
        chk("a_tag", 64'(a_out_tag), 64'(e[15:0]));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [71:0] e;
    if (b_out_vld && b_out_rdy) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra_output got=%h exp=none", b_out_result);
      end else begin
        e = qb.pop_front();
        chk("b_result", b_out_result, e[71:8]);
        chk("b_tag", 64'(b_out_tag), 64'(e[7:0]));
      end
    end
  end

  initial begin
    int n;
    a_rstz = 1'b0; a_in_vld = 1'b1; a_in_op = ALU_ADD; a_in_op1 = 32'd5; a_in_op2 = 32'd7;
    a_in_hz1 = '0; a_in_hz2 = '0; a_in_tag = 16'h1234; a_fwd_data = '0; a_fwd_vld = '0;
    a_out_rdy = 1'b1;
    b_rstz = 1'b0; b_in_vld = 1'b0; b_in_op = ALU_ADD; b_in_op1 = '0; b_in_op2 = '0;
    b_in_hz1 = '0; b_in_hz2 = '0; b_in_tag = '0; b_fwd_data = '0; b_fwd_vld = '0;
    b_out_rdy = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_vld", 64'(a_out_vld), 64'd0);
    chk("rst_out_result", 64'(a_out_result), 64'd0);
    chk("rst_out_tag", 64'(a_out_tag), 64'd0);
    chk("rst_in_rdy", 64'(a_in_rdy), 64'd0);
    a_rstz = 1'b1; b_rstz = 1'b1; a_in_vld = 1'b0;
    @(posedge clk); #1;

    send_a(ALU_ADD, 32'd5, 32'd7, 16'h1234, 32'd12, 1);
    chk("add_latency", 64'(a_out_vld), 64'd1);

    // Forwarding: source 0 wins over source 1.
    a_in_hz1 = 2'b11; a_fwd_data = {32'h55, 32'hAA}; a_fwd_vld = 2'b01;
    send_a(ALU_AND, 32'h1234, 32'hFF, 16'h0010, 32'hAA, 1);
    a_fwd_vld = 2'b10; a_fwd_data = {32'h55, 32'h3C};
    a_in_op = ALU_AND; a_in_op1 = 32'h1234; a_in_op2 = 32'hFF; a_in_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fwd_stall_rdy", 64'(a_in_rdy), 64'd0);
    end
    @(posedge clk); #1;
    a_fwd_vld = 2'b11;
    send_a(ALU_AND, 32'h1234, 32'hFF, 16'h0011, 32'h3C, 1);
    a_in_hz1 = 2'b00; a_in_hz2 = 2'b10;
    send_a(ALU_ADD, 32'd1, 32'h9999, 16'h0012, 32'h56, 1);
    a_in_hz2 = 2'b11;
    send_a(ALU_ADD, 32'd1, 32'h9999, 16'h0013, 32'h3D, 1);
    a_in_hz2 = 2'b00;

    // Back-to-back SUBs against a toggling out_rdy.
    fork
      begin
        send_a(ALU_SUB, 32'd0, 32'd1, 16'h0201, 32'hFFFF_FFFF, 1);
        send_a(ALU_SUB, 32'd10, 32'd3, 16'h0202, 32'd7, 1);
        send_a(ALU_SUB, 32'd100, 32'd50, 16'h0203, 32'd50, 1);
        send_a(ALU_SUB, 32'h8000_0000, 32'd1, 16'h0204, 32'h7FFF_FFFF, 1);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          a_out_rdy = (i % 3 != 1);
          @(posedge clk); #1;
        end
        a_out_rdy = 1'b1;
      end
    join

    // SRA by 4 right behind an ADD: drain and shift start share an edge.
    send_a(ALU_ADD, 32'd1, 32'd1, 16'h0001, 32'd2, 1);
    a_in_op = ALU_SRA; a_in_op1 = 32'h8000_0000; a_in_op2 = 32'd4; a_in_tag = 16'h00A5;
    a_in_vld = 1'b1;
    @(negedge clk);
    chk("sra_accept_rdy", 64'(a_in_rdy), 64'd1);
    if (a_in_rdy) qa.push_back({32'hF800_0000, 16'h00A5});
    @(posedge clk); #1;
    a_in_vld = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("sra_busy_rdy", 64'(a_in_rdy), 64'd0);
      chk("sra_busy_vld", 64'(a_out_vld), 64'd0);
    end
    @(negedge clk);
    chk("sra_done_vld", 64'(a_out_vld), 64'd1);
    chk("sra_done_rdy", 64'(a_in_rdy), 64'd1);
    @(posedge clk); #1;

    send_a(ALU_SLL, 32'h1234, 32'h20, 16'h0300, 32'h1234, 1);
    chk("shamt0_latency", 64'(a_out_vld), 64'd1);
    send_a(ALU_SRL, 32'h8000_0000, 32'h21, 16'h0301, 32'h4000_0000, 1);
    chk("shamt1_vld_early", 64'(a_out_vld), 64'd0);
    @(posedge clk); #1;
    chk("shamt1_vld_done", 64'(a_out_vld), 64'd1);
    send_a(ALU_SLL, 32'd3, 32'd31, 16'h0302, 32'h8000_0000, 1);

    // Reset while cnt=3: the shift result must never appear.
    send_a(ALU_SRL, 32'hF0, 32'd5, 16'h0400, 32'h0, 0);
    @(posedge clk); @(posedge clk); #1;
    a_rstz = 1'b0;
    @(negedge clk);
    a_rstz = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_vld", 64'(a_out_vld), 64'd0);
    end
    @(posedge clk); #1;
    send_a(ALU_ADD, 32'd2, 32'd3, 16'h0077, 32'd5, 1);
    chk("post_abort_latency", 64'(a_out_vld), 64'd1);

    send_a(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 16'h0500, 32'd1, 1);
    send_a(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 16'h0501, 32'd0, 1);
    send_a(ALU_OR, 32'hF0, 32'h0F, 16'h0502, 32'hFF, 1);
    send_a(ALU_XOR, 32'hFF, 32'h0F, 16'h0503, 32'hF0, 1);
    send_a(ALU_PASS2, 32'h1111, 32'hDEAD, 16'h0504, 32'hDEAD, 1);

    // 64-bit instance with the barrel shifter.
    send_b(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h01, 64'd1);
    chk("b_add_latency", 64'(b_out_vld), 64'd1);
    send_b(ALU_SUB, 64'd0, 64'd1, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF);
    send_b(ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'h03, 64'd1);
    send_b(ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'h04, 64'd0);
    send_b(ALU_SRA, 64'h8000_0000_0000_0000, 64'd4, 8'h05, 64'hF800_0000_0000_0000);
    send_b(ALU_SLL, 64'd1, 64'h7F, 8'h06, 64'h8000_0000_0000_0000);
    send_b(ALU_SRL, 64'h8000_0000_0000_0000, 64'h41, 8'h07, 64'h4000_0000_0000_0000);
    b_in_hz1 = 2'b01; b_fwd_vld = 2'b01; b_fwd_data = {64'h0, 64'h0123_4567_89AB_CDEF};
    send_b(ALU_AND, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h08, 64'h0123_4567_89AB_CDEF);
    b_in_hz1 = 2'b00;

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kronos_ex_pipe.md
# kronos_ex_pipe

Parametrised execute pipestage for the Kronos core. It sits between Decode and WriteBack. Operands are forwarded from `NFWD` prioritised sources instead of one. `XLEN` and the pass-through tag width are configurable. `SHIFT_ITER` selects an area-saving iterative shifter that makes shifts multi-cycle. The block registers one result per accepted instruction and holds it until WriteBack takes it.

## Interface
Parameters:
- `XLEN`, 32: datapath width; must be a power of two, ≥ 8.
- `NFWD`, 2: number of forwarding sources; index 0 has highest priority (youngest producer).
- `TAGW`, 16: width of the opaque WB-control tag passed through unchanged (rd, rd_write, ld/st controls, illegal).
- `SHIFT_ITER`, 0: 0 gives a single-cycle barrel shift; 1 gives an iterative shift of 1 bit per cycle.

Ports (reset rstz, asynchronous, active-low; clock clk):
- `clk`  in  1  clock
- `rstz`  in  1  asynchronous active-low reset
- `in_vld`  in  1  decoded instruction valid
- `in_rdy`  out  1  stage can accept
- `in_op`  in  `alu_op_t` (4)  operation
- `in_op1`, `in_op2`  in  `XLEN` each  operands from Decode (possibly stale)
- `in_hz1`, `in_hz2`  in  `NFWD` each  per-source hazard flags for op1 and op2
- `in_tag`  in  `TAGW`  WB controls
- `fwd_data`  in  `NFWD`×`XLEN`  forwarded values
- `fwd_vld`  in  `NFWD`  forwarded value available
- `out_vld`  out  1  result valid
- `out_rdy`  in  1  WriteBack accepts
- `out_result`  out  `XLEN`  result
- `out_tag`  out  `TAGW`  registered `in_tag`

## Operation
- Operand select: for each operand k, the lowest index i with `in_hzk[i]=1` selects `fwd_data[i]`. If no flag is set, `in_opk` is used.
- Stall: `stall` is 1 when either operand's selected source has `fwd_vld[i]=0`.
- Ops: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASS2.
  - SLT and SLTU produce 1 or 0, zero-extended.
  - The shift amount is `op2[$clog2(XLEN)-1:0]`; upper bits are ignored.
  - Arithmetic wraps modulo 2^XLEN.
- Accept: a transfer happens when `in_vld & in_rdy`. Selected operands, op and tag are captured on that edge. Forwarding inputs are not used after capture.
- `in_rdy = (~out_vld | out_rdy) & ~busy & ~stall`.
- FSM (used only when `SHIFT_ITER=1`):
  - IDLE → SHIFT: on accepting a shift op with shamt ≠ 0. `cnt` loads shamt.
  - SHIFT: each cycle shifts the working register by 1 bit (SRA sign-fills) and decrements `cnt`.
  - SHIFT → IDLE: at `cnt=1`, with `out_vld` set on that edge.
  - In SHIFT, `busy=1`.
  - Non-shift ops, and shifts with shamt=0, complete as single-cycle ops.
- Output: `out_vld` rises when a result completes. It holds with stable `out_result`/`out_tag` until `out_vld & out_rdy`, and clears on that edge unless a new result completes on the same edge.
- Simultaneous drain and accept of a single-cycle op: `out_vld` stays 1 and the output updates to the new result.
- Simultaneous drain and accept of a multi-cycle shift: `out_vld` goes 0 until the shift completes.
- A shift always completes into an empty output register, so no overflow case exists.

## Timing
- Reset values: `out_vld=0`, `out_result=0`, `out_tag=0`, FSM=IDLE, `cnt=0`, `busy=0`. With `rstz` low, `in_rdy=0` when `busy` would be set. Reset during SHIFT aborts the shift and discards the result.
- Single-cycle op accepted at edge N: `out_vld=1` after edge N.
- Iterative shift with shamt s ≥ 1 accepted at edge N: `out_vld=1` after edge N+s. `in_rdy=0` from N through N+s−1 and returns to 1 after N+s if `out_rdy` allows.
- `in_rdy` depends combinationally on `out_rdy`, `fwd_vld`, `in_hz1` and `in_hz2`. There is no combinational path from any input to `out_*`.
- Throughput for single-cycle ops is 1 per cycle while `out_rdy=1`.

## Structure
- `alu_op_t` (4-bit enum) goes in `kronos_types`; `XLEN`-independent.
- Sub-module `kronos_shift_iter`: holds the working register, `cnt`, start/done and `busy`, and carries the FSM. It is instantiated only under `SHIFT_ITER=1` (generate). Otherwise a combinational barrel shift is used.
- Forwarding select is a generate loop with a priority encoder per operand, using no latches.

## Test plan
- Reset with `in_vld=1` held → all outputs 0. After release, ADD 5+7 accepted → `out_vld` next cycle, `out_result=12`, tag echoed.
- NFWD=2, `in_hz1=2'b11`, `fwd_data[0]=0xAA`, `fwd_data[1]=0x55`, `fwd_vld=2'b01`, AND with op2=0xFF → source 0 selected, result 0xAA. Then with `fwd_vld=2'b10` → `in_rdy=0` until `fwd_vld[0]` rises.
- Back-to-back SUB stream with `out_rdy` toggling 1,0,1 → no loss or duplicate. Output holds while `out_rdy=0`. SUB 0−1 = 0xFFFFFFFF.
- SHIFT_ITER=1, SRA 0x80000000 by 4 → `in_rdy=0` for 4 cycles, result 0xF8000000 at edge N+4. Shamt 0 → 1-cycle latency. op2=0x21 → shift by 1.
- SHIFT_ITER=1, `rstz` pulsed low mid-shift (cnt=3) → `out_vld` stays 0 and the next ADD completes normally.
- SLT −1<1 → 1. SLTU 0xFFFFFFFF<1 → 0. Repeat the same checks at XLEN=64 with 64-bit values.
